// File: rtl/pipe_hazard_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: shadows in-flight dst/control
// fields and derives EX forwarding selects, load-use stalls, branch flushes and event counts.
module pipe_hazard_unit #(
    parameter int unsigned RA_W   = 5,
    parameter int unsigned NSTG   = 3,
    parameter int unsigned LD_FWD = 2,
    parameter int unsigned BR_STG = 1,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned FS_W   = $clog2(NSTG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic [RA_W-1:0]  id_dst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             branch_taken,
    output logic             stall,
    output logic             flush,
    output logic [FS_W-1:0]  fwd_a,
    output logic [FS_W-1:0]  fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [NSTG-1:0]           s_valid, s_rw, s_mr;
    logic [NSTG-1:0][RA_W-1:0] s_dst;
    logic [RA_W-1:0]           ex_rs, ex_rt;

    logic [NSTG-1:0]           n_valid, n_rw, n_mr;
    logic [NSTG-1:0][RA_W-1:0] n_dst;
    logic [RA_W-1:0]           n_ex_rs, n_ex_rt;

    logic                      lu_a, lu_b;

    // EX operand forwarding: scanning oldest to youngest lets the youngest producer win
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = int'(NSTG) - 1; k >= 1; k--) begin
            if (s_valid[k] && s_rw[k] && (ex_rs != '0) && (s_dst[k] == ex_rs))
                fwd_a = FS_W'(k);
            if (s_valid[k] && s_rw[k] && (ex_rt != '0) && (s_dst[k] == ex_rt))
                fwd_b = FS_W'(k);
        end
    end

    // Load-use detection against the youngest producer of each ID source
    always_comb begin
        lu_a = 1'b0;
        lu_b = 1'b0;
        for (int j = int'(NSTG) - 1; j >= 0; j--) begin
            if (s_valid[j] && s_rw[j] && (id_rs != '0) && (s_dst[j] == id_rs))
                lu_a = s_mr[j] && ((j + 1) < int'(LD_FWD));
            if (s_valid[j] && s_rw[j] && (id_rt != '0) && (s_dst[j] == id_rt))
                lu_b = s_mr[j] && ((j + 1) < int'(LD_FWD));
        end
        flush = branch_taken;
        stall = id_valid && (lu_a || lu_b) && !branch_taken;
    end

    // Shadow pipeline next state: flush beats stall beats normal advance
    always_comb begin
        n_valid = s_valid;
        n_rw    = s_rw;
        n_mr    = s_mr;
        n_dst   = s_dst;
        n_ex_rs = ex_rs;
        n_ex_rt = ex_rt;
        for (int k = 1; k < int'(NSTG); k++) begin
            n_valid[k] = s_valid[k-1];
            n_rw[k]    = s_rw[k-1];
            n_mr[k]    = s_mr[k-1];
            n_dst[k]   = s_dst[k-1];
        end
        if (flush) begin
            for (int k = 0; k < int'(NSTG); k++) begin
                if (k < int'(BR_STG))
                    n_valid[k] = 1'b0;
            end
            n_valid[0] = 1'b0;
            n_rw[0]    = 1'b0;
            n_mr[0]    = 1'b0;
            n_dst[0]   = '0;
            n_ex_rs    = '0;
            n_ex_rt    = '0;
        end else if (stall) begin
            n_valid[0] = 1'b0;
            n_rw[0]    = 1'b0;
            n_mr[0]    = 1'b0;
            n_dst[0]   = '0;
        end else begin
            n_valid[0] = id_valid;
            n_rw[0]    = id_regwrite;
            n_mr[0]    = id_memread;
            n_dst[0]   = id_dst;
            n_ex_rs    = id_rs;
            n_ex_rt    = id_rt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_valid   <= '0;
            s_rw      <= '0;
            s_mr      <= '0;
            s_dst     <= '0;
            ex_rs     <= '0;
            ex_rt     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            s_valid <= n_valid;
            s_rw    <= n_rw;
            s_mr    <= n_mr;
            s_dst   <= n_dst;
            ex_rs   <= n_ex_rs;
            ex_rt   <= n_ex_rt;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed instruction sequences plus randomized traffic
// checked against an instruction-level model of the in-flight pipeline.
module tb_pipe_hazard_unit;

    localparam int NSTG   = 3;
    localparam int LD_FWD = 2;
    localparam int BR_STG = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, id_valid, id_regwrite, id_memread, branch_taken;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       stall, flush, stall2, flush2;
    logic [1:0] fwd_a, fwd_b, fwd_a2, fwd_b2;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  stall_cnt2, flush_cnt2;

    pipe_hazard_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .branch_taken(branch_taken), .stall(stall), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_dst(id_dst), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .branch_taken(branch_taken), .stall(stall2), .flush(flush2),
        .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    int checks = 0;
    int errors = 0;

    // Instruction-level model: one record per in-flight instruction after ID
    bit         m_v  [NSTG];
    bit         m_rw [NSTG];
    bit         m_mr [NSTG];
    logic [4:0] m_dst[NSTG];
    logic [4:0] m_ex_rs, m_ex_rt;
    bit         m_ex_known;
    int         m_scnt, m_fcnt, m_scnt2, m_fcnt2;

    function automatic bit m_prod(int k, logic [4:0] r);
        return m_v[k] && m_rw[k] && (r != 5'd0) && (m_dst[k] == r);
    endfunction

    function automatic int m_fwd(logic [4:0] r);
        for (int k = 1; k < NSTG; k++)
            if (m_prod(k, r)) return k;
        return 0;
    endfunction

    function automatic bit m_lu(logic [4:0] r);
        for (int j = 0; j < NSTG; j++)
            if (m_prod(j, r)) return m_mr[j] && (j + 1 < LD_FWD);
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        return id_valid && !branch_taken && (m_lu(id_rs) || m_lu(id_rt));
    endfunction

    task automatic drive(bit v, logic [4:0] rs, logic [4:0] rt, logic [4:0] dst,
                         bit rw, bit mr, bit br);
        id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
        id_regwrite = rw; id_memread = mr; branch_taken = br;
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance one clock and move the model the same way
    task automatic tick();
        bit st, fl;
        st = m_stall();
        fl = branch_taken;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < NSTG; k++) m_v[k] = 1'b0;
            m_ex_rs = 5'd0; m_ex_rt = 5'd0; m_ex_known = 1'b1;
            m_scnt = 0; m_fcnt = 0; m_scnt2 = 0; m_fcnt2 = 0;
        end else begin
            if (st) begin
                m_scnt  = (m_scnt  < 65535) ? m_scnt + 1  : m_scnt;
                m_scnt2 = (m_scnt2 < 3)     ? m_scnt2 + 1 : m_scnt2;
            end
            if (fl) begin
                m_fcnt  = (m_fcnt  < 65535) ? m_fcnt + 1  : m_fcnt;
                m_fcnt2 = (m_fcnt2 < 3)     ? m_fcnt2 + 1 : m_fcnt2;
            end
            for (int k = NSTG - 1; k >= 1; k--) begin
                m_v[k] = m_v[k-1]; m_rw[k] = m_rw[k-1];
                m_mr[k] = m_mr[k-1]; m_dst[k] = m_dst[k-1];
            end
            if (fl) begin
                for (int k = 0; k < BR_STG; k++) m_v[k] = 1'b0;
                m_v[0] = 1'b0;
                m_ex_known = 1'b0;
            end else if (st) begin
                m_v[0] = 1'b0;
            end else begin
                m_v[0] = id_valid; m_rw[0] = id_regwrite;
                m_mr[0] = id_memread; m_dst[0] = id_dst;
                m_ex_rs = id_rs; m_ex_rt = id_rt; m_ex_known = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nop();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        nop();
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0d expected 0", stall); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %0d expected 0", flush); end
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL reset_fwd_a got %0d expected 0", fwd_a); end
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL reset_fwd_b got %0d expected 0", fwd_b); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d expected 0", stall_cnt); end
        checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_flush_cnt got %0d expected 0", flush_cnt); end
    endtask

    task automatic test_dep_alu();
        do_reset();
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);   // add $3,$1,$2
        tick();
        drive(1'b1, 5'd3, 5'd1, 5'd4, 1'b1, 1'b0, 1'b0);   // sub $4,$3,$1
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL dep_stall got %0d expected 0", stall); end
        tick();
        nop();
        checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL dep_fwd_a got %0d expected 1", fwd_a); end
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL dep_fwd_b got %0d expected 0", fwd_b); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw $5,0($0)
        tick();
        drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);   // add $6,$5,$5
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_first got %0d expected 1", stall); end
        tick();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_second got %0d expected 0", stall); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d expected 1", stall_cnt); end
        tick();
        nop();
        checks++; if (fwd_a !== 2'd2) begin errors++; $display("FAIL lu_fwd_a got %0d expected 2", fwd_a); end
        checks++; if (fwd_b !== 2'd2) begin errors++; $display("FAIL lu_fwd_b got %0d expected 2", fwd_b); end
    endtask

    task automatic test_masking();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw $5
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);   // addi $5,$0,7
        tick();
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);   // add $6,$5,$0
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mask_stall got %0d expected 0", stall); end
        tick();
        nop();
        checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL mask_fwd_a got %0d expected 1", fwd_a); end
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL mask_fwd_b got %0d expected 0", fwd_b); end
    endtask

    task automatic test_flush_loaduse();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw $5
        tick();
        drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b1);   // add $6,$5,$5 with branch taken
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL fl_flush got %0d expected 1", flush); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %0d expected 0", stall); end
        tick();
        drive(1'b1, 5'd6, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0);   // reader of $6 from target path
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL fl_flush_cnt got %0d expected 1", flush_cnt); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL fl_stall_cnt got %0d expected 0", stall_cnt); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL fl_flush_drop got %0d expected 0", flush); end
        tick();
        nop();
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL fl_killed_fwd got %0d expected 0", fwd_a); end
    endtask

    task automatic test_zero_dst();
        do_reset();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);   // lw $0
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);   // reader of $0
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got %0d expected 0", stall); end
        tick();
        nop();
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL zero_fwd_a got %0d expected 0", fwd_a); end
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL zero_fwd_b got %0d expected 0", fwd_b); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
            tick();
            drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
            tick();
            tick();
        end
        nop();
        checks++; if (stall_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_stall_cnt got %0d expected 3", stall_cnt2); end
        checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL wide_stall_cnt got %0d expected 4", stall_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall got %0d expected 1", stall); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall got %0d expected 0", stall); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL mid_flush got %0d expected 0", flush); end
        checks++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin errors++; $display("FAIL mid_fwd got %0d/%0d expected 0/0", fwd_a, fwd_b); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL mid_stall_cnt got %0d expected 0", stall_cnt); end
        checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL mid_flush_cnt got %0d expected 0", flush_cnt); end
    endtask

    task automatic test_random();
        bit         v, rw, mr, br, exp_st;
        logic [4:0] rs, rt, dst;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            v   = ($urandom_range(7) != 0);
            rs  = 5'($urandom_range(3));
            rt  = 5'($urandom_range(3));
            dst = 5'($urandom_range(3));
            mr  = ($urandom_range(2) == 0);
            rw  = mr || ($urandom_range(3) != 0);
            br  = ($urandom_range(7) == 0);
            drive(v, rs, rt, dst, rw, mr, br);
            exp_st = m_stall();
            checks++; if (stall !== exp_st) begin errors++; $display("FAIL rnd_stall cyc %0d got %0d expected %0d", c, stall, exp_st); end
            checks++; if (flush !== br) begin errors++; $display("FAIL rnd_flush cyc %0d got %0d expected %0d", c, flush, br); end
            if (m_ex_known) begin
                checks++; if (int'(fwd_a) != m_fwd(m_ex_rs)) begin errors++; $display("FAIL rnd_fwd_a cyc %0d got %0d expected %0d", c, fwd_a, m_fwd(m_ex_rs)); end
                checks++; if (int'(fwd_b) != m_fwd(m_ex_rt)) begin errors++; $display("FAIL rnd_fwd_b cyc %0d got %0d expected %0d", c, fwd_b, m_fwd(m_ex_rt)); end
            end
            checks++; if (int'(stall_cnt) != m_scnt || int'(flush_cnt) != m_fcnt) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d/%0d expected %0d/%0d", c, stall_cnt, flush_cnt, m_scnt, m_fcnt); end
            checks++; if (int'(stall_cnt2) != m_scnt2 || int'(flush_cnt2) != m_fcnt2) begin errors++; $display("FAIL rnd_sat_cnt cyc %0d got %0d/%0d expected %0d/%0d", c, stall_cnt2, flush_cnt2, m_scnt2, m_fcnt2); end
            rst = ($urandom_range(99) == 0);
            tick();
            rst = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        m_ex_known = 1'b1;
        for (int k = 0; k < NSTG; k++) begin
            m_v[k] = 1'b0; m_rw[k] = 1'b0; m_mr[k] = 1'b0; m_dst[k] = 5'd0;
        end
        m_ex_rs = 5'd0; m_ex_rt = 5'd0;
        m_scnt = 0; m_fcnt = 0; m_scnt2 = 0; m_fcnt2 = 0;
        nop();
        @(negedge clk);
        test_reset();
        test_dep_alu();
        test_load_use();
        test_masking();
        test_flush_loaduse();
        test_zero_dst();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
